// File: rtl/user_input_ctrl_if.sv
// Request/acknowledge bus between the user input controller and the LRU
// storage block.
//
// Signals:
//   req_o    request valid, level, held until acknowledged
//   we_o     1 = write, 0 = read; valid while req_o is high
//   wdata_o  write data, stable while req_o is high
//   busy_o   request outstanding (mirrors req_o)
//   ack_i    LRU accepted the current request (single-cycle pulse or level)
//
// Modports: master = controller side, slave = LRU storage side.
interface user_input_ctrl_if;
    logic        req_o;
    logic        we_o;
    logic [15:0] wdata_o;
    logic        busy_o;
    logic        ack_i;

    modport master (
        output req_o,
        output we_o,
        output wdata_o,
        output busy_o,
        input  ack_i
    );

    modport slave (
        input  req_o,
        input  we_o,
        input  wdata_o,
        input  busy_o,
        output ack_i
    );
endinterface

// File: rtl/user_input_ctrl.sv
// User input controller: conditions the raw board buttons (2-FF sync,
// debounce, rising-edge press pulse), runs the top-level one-hot mode FSM,
// owns the counter run/stop flag and issues read/write requests to the LRU
// storage block with the switch value as write data.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   btn_i[2:0] raw buttons, async, active-high: [0] mode, [1] action, [2] home
//   sw_i[15:0] board switches, async, used as write data
//   state_o    one-hot mode: 100 CNT_EN, 010 LRU_WR, 001 LRU_RD
//   cnt_run_o  counter enable flag
//   lru        request/ack bus to the LRU block (master side)
//
// Request FSM states:
//   state  | meaning
//   S_IDLE | no request outstanding; button presses are acted on
//   S_WAIT | req_o high, waiting for ack_i; presses are dropped
module user_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [2:0]                btn_i,
    input  logic [15:0]               sw_i,
    output logic [2:0]                state_o,
    output logic                      cnt_run_o,
    user_input_ctrl_if.master         lru
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] M_CNT = 3'b100;
    localparam logic [2:0] M_WR  = 3'b010;
    localparam logic [2:0] M_RD  = 3'b001;

    typedef enum logic {S_IDLE, S_WAIT} fsm_t;

    // Button conditioning
    logic [2:0]         btn_s1;
    logic [2:0]         btn_s2;
    logic [2:0]         db;
    logic [2:0]         db_d;
    logic [2:0]         press;
    logic [2:0][CW-1:0] cnt;

    // Switch synchroniser
    logic [15:0] sw_s1;
    logic [15:0] sw_s2;

    // Control state
    fsm_t        fsm, fsm_n;
    logic [2:0]  mode, mode_n;
    logic        run, run_n;
    logic        we_r, we_n;
    logic [15:0] wdata_r, wdata_n;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            db     <= '0;
            db_d   <= '0;
            press  <= '0;
            cnt    <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_i;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_i;
            sw_s2  <= sw_s1;
            db_d   <= db;
            // Registered rising edge of the debounced level: one cycle wide.
            press  <= db & ~db_d;
            for (int i = 0; i < 3; i++) begin
                if (btn_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    // DEBOUNCE_CYCLES consecutive differing samples seen.
                    db[i]  <= btn_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm     <= S_IDLE;
            mode    <= M_CNT;
            run     <= 1'b0;
            we_r    <= 1'b0;
            wdata_r <= '0;
        end else begin
            fsm     <= fsm_n;
            mode    <= mode_n;
            run     <= run_n;
            we_r    <= we_n;
            wdata_r <= wdata_n;
        end
    end

    always_comb begin
        fsm_n   = fsm;
        mode_n  = mode;
        run_n   = run;
        we_n    = we_r;
        wdata_n = wdata_r;
        case (fsm)
            S_IDLE: begin
                // Priority home > action > mode for coincident presses.
                if (press[2]) begin
                    mode_n = M_CNT;
                end else if (press[1]) begin
                    case (mode)
                        M_CNT: run_n = ~run;
                        M_WR: begin
                            fsm_n   = S_WAIT;
                            we_n    = 1'b1;
                            wdata_n = sw_s2;
                        end
                        M_RD: begin
                            fsm_n   = S_WAIT;
                            we_n    = 1'b0;
                            wdata_n = sw_s2;
                        end
                        default: mode_n = M_CNT;
                    endcase
                end else if (press[0]) begin
                    case (mode)
                        M_CNT:   mode_n = M_WR;
                        M_WR:    mode_n = M_RD;
                        default: mode_n = M_CNT;
                    endcase
                end
            end
            S_WAIT: begin
                if (lru.ack_i) begin
                    fsm_n = S_IDLE;
                end
            end
            default: fsm_n = S_IDLE;
        endcase
    end

    assign state_o     = mode;
    assign cnt_run_o   = run;
    assign lru.req_o   = (fsm == S_WAIT);
    assign lru.busy_o  = (fsm == S_WAIT);
    assign lru.we_o    = we_r;
    assign lru.wdata_o = wdata_r;

endmodule

// File: tb/tb_user_input_ctrl.sv
// Testbench for user_input_ctrl with DEBOUNCE_CYCLES = 4: a table of button
// presses with expected mode/run/request results, plus hand-written
// sequences for latency, glitch rejection, handshake and reset corners.
module tb_user_input_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [2:0]  btn_i;
    logic [15:0] sw_i;
    logic [2:0]  state_o;
    logic        cnt_run_o;

    user_input_ctrl_if lru_bus ();

    user_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .btn_i     (btn_i),
        .sw_i      (sw_i),
        .state_o   (state_o),
        .cnt_run_o (cnt_run_o),
        .lru       (lru_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Request monitor: counts cycles with req_o high, remembers we/wdata.
    int          req_total = 0;
    logic        mon_we    = 1'b0;
    logic [15:0] mon_wdata = '0;
    always @(negedge clk) begin
        if (lru_bus.req_o === 1'b1) begin
            req_total = req_total + 1;
            mon_we    = lru_bus.we_o;
            mon_wdata = lru_bus.wdata_o;
        end
    end

    typedef struct {
        logic [2:0]  btn;
        logic [15:0] sw;
        logic [2:0]  st;
        logic        run;
        int          reqs;
        logic        we;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic press(input logic [2:0] b);
        btn_i = b;
        repeat (10) tick();
        btn_i = 3'b000;
        repeat (10) tick();
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (lru_bus.req_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(lru_bus.req_o), 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int base;
        rst_i           = 1'b1;
        btn_i           = 3'b000;
        sw_i            = 16'h0000;
        lru_bus.ack_i   = 1'b0;

        //         btn     sw        state   run   reqs we
        tbl[0]  = '{3'b001, 16'h0000, 3'b010, 1'b0, 0, 1'b0};
        tbl[1]  = '{3'b001, 16'h0000, 3'b001, 1'b0, 0, 1'b0};
        tbl[2]  = '{3'b001, 16'h0000, 3'b100, 1'b0, 0, 1'b0};
        tbl[3]  = '{3'b010, 16'h0000, 3'b100, 1'b1, 0, 1'b0};
        tbl[4]  = '{3'b001, 16'h0000, 3'b010, 1'b1, 0, 1'b0};
        tbl[5]  = '{3'b010, 16'h1234, 3'b010, 1'b1, 1, 1'b1};
        tbl[6]  = '{3'b100, 16'h0000, 3'b100, 1'b1, 0, 1'b0};
        tbl[7]  = '{3'b010, 16'h0000, 3'b100, 1'b0, 0, 1'b0};
        tbl[8]  = '{3'b001, 16'h0000, 3'b010, 1'b0, 0, 1'b0};
        tbl[9]  = '{3'b011, 16'hBEEF, 3'b010, 1'b0, 1, 1'b1};
        tbl[10] = '{3'b110, 16'h0000, 3'b100, 1'b0, 0, 1'b0};
        tbl[11] = '{3'b001, 16'h0000, 3'b010, 1'b0, 0, 1'b0};
        tbl[12] = '{3'b001, 16'h0000, 3'b001, 1'b0, 0, 1'b0};
        tbl[13] = '{3'b010, 16'h0F0F, 3'b001, 1'b0, 1, 1'b0};
        tbl[14] = '{3'b101, 16'h0000, 3'b100, 1'b0, 0, 1'b0};
        tbl[15] = '{3'b011, 16'h0000, 3'b100, 1'b1, 0, 1'b0};

        repeat (3) tick();
        check("rst_state", 32'(state_o), 32'h4);
        check("rst_run", 32'(cnt_run_o), 32'd0);
        check("rst_req", 32'(lru_bus.req_o), 32'd0);
        check("rst_we", 32'(lru_bus.we_o), 32'd0);
        check("rst_wdata", 32'(lru_bus.wdata_o), 32'd0);
        check("rst_busy", 32'(lru_bus.busy_o), 32'd0);
        rst_i = 1'b0;
        repeat (2) tick();

        // Press latency: change before edge k, state moves at edge k+7.
        btn_i = 3'b001;
        repeat (7) tick();
        check("lat_before", 32'(state_o), 32'h4);
        tick();
        check("lat_at", 32'(state_o), 32'h2);
        repeat (12) tick();
        btn_i = 3'b000;
        repeat (10) tick();
        check("lat_release", 32'(state_o), 32'h2);

        do_reset();

        // Table: ack held high, so each request lasts exactly one cycle.
        lru_bus.ack_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sw_i = tbl[i].sw;
            base = req_total;
            press(tbl[i].btn);
            check($sformatf("v%0d_state", i), 32'(state_o), 32'(tbl[i].st));
            check($sformatf("v%0d_run", i), 32'(cnt_run_o), 32'(tbl[i].run));
            check($sformatf("v%0d_reqs", i), 32'(req_total - base), 32'(tbl[i].reqs));
            if (tbl[i].reqs > 0) begin
                check($sformatf("v%0d_we", i), 32'(mon_we), 32'(tbl[i].we));
                check($sformatf("v%0d_wdata", i), 32'(mon_wdata), 32'(tbl[i].sw));
            end
        end
        lru_bus.ack_i = 1'b0;

        // Glitch rejection at the debounce boundary (state 100, run 1).
        btn_i = 3'b010;
        repeat (2) tick();
        btn_i = 3'b000;
        repeat (12) tick();
        check("glitch_action", 32'(cnt_run_o), 32'd1);
        btn_i = 3'b001;
        repeat (3) tick();
        btn_i = 3'b000;
        repeat (12) tick();
        check("glitch_3", 32'(state_o), 32'h4);
        btn_i = 3'b001;
        repeat (4) tick();
        btn_i = 3'b000;
        repeat (12) tick();
        check("pulse_4", 32'(state_o), 32'h2);
        press(3'b100);
        check("home", 32'(state_o), 32'h4);

        // Write request with delayed ack; wdata captured at req rise.
        press(3'b001);
        sw_i = 16'hA5C3;
        repeat (3) tick();
        btn_i = 3'b010;
        wait_req("wr_req");
        check("wr_we", 32'(lru_bus.we_o), 32'd1);
        check("wr_wdata", 32'(lru_bus.wdata_o), 32'hA5C3);
        check("wr_busy", 32'(lru_bus.busy_o), 32'd1);
        btn_i = 3'b000;
        sw_i  = 16'h0000;
        repeat (5) tick();
        check("wr_hold", 32'(lru_bus.req_o), 32'd1);
        check("wr_wdata_hold", 32'(lru_bus.wdata_o), 32'hA5C3);
        lru_bus.ack_i = 1'b1;
        tick();
        lru_bus.ack_i = 1'b0;
        check("wr_done_req", 32'(lru_bus.req_o), 32'd0);
        check("wr_done_busy", 32'(lru_bus.busy_o), 32'd0);
        repeat (10) tick();
        check("wr_state", 32'(state_o), 32'h2);

        // Presses during WAIT are dropped.
        btn_i = 3'b010;
        wait_req("d_req");
        btn_i = 3'b000;
        repeat (10) tick();
        press(3'b001);
        press(3'b100);
        check("wait_state", 32'(state_o), 32'h2);
        check("wait_req_held", 32'(lru_bus.req_o), 32'd1);
        lru_bus.ack_i = 1'b1;
        tick();
        lru_bus.ack_i = 1'b0;
        repeat (20) tick();
        check("no_delayed", 32'(state_o), 32'h2);
        check("no_delayed_req", 32'(lru_bus.req_o), 32'd0);

        // Read with ack tied high; ack while idle has no effect.
        lru_bus.ack_i = 1'b1;
        base = req_total;
        press(3'b001);
        check("rd_mode", 32'(state_o), 32'h1);
        check("idle_ack", 32'(req_total - base), 32'd0);
        press(3'b010);
        check("rd_req_cycles", 32'(req_total - base), 32'd1);
        check("rd_we", 32'(mon_we), 32'd0);
        check("rd_state", 32'(state_o), 32'h1);
        lru_bus.ack_i = 1'b0;

        // Reset during WAIT.
        check("f_run_before", 32'(cnt_run_o), 32'd1);
        btn_i = 3'b010;
        wait_req("f_req");
        rst_i = 1'b1;
        tick();
        check("f_req", 32'(lru_bus.req_o), 32'd0);
        check("f_busy", 32'(lru_bus.busy_o), 32'd0);
        check("f_state", 32'(state_o), 32'h4);
        check("f_run", 32'(cnt_run_o), 32'd0);
        rst_i = 1'b0;
        btn_i = 3'b000;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
